// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM/owner encodings and fetch-word helper for mem_arbiter
package mem_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    function automatic logic [31:0] fetch_word(input logic [63:0] word, input logic hi);
        return hi ? word[63:32] : word[31:0];
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - grant decision; round-robin on conflict when MEM_ARB_RR_EN is defined
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic rr_ptr,
    output logic grant_valid,
    output logic grant_owner
);

    assign grant_valid = i_req | d_req;

`ifdef MEM_ARB_RR_EN
    // rr_ptr holds the owner served last, so a conflict goes to the other one
    always_comb begin
        grant_owner = OWN_I;
        if (i_req && d_req)
            grant_owner = ~rr_ptr;
        else if (d_req)
            grant_owner = OWN_D;
    end
`else
    logic unused_rr;
    assign unused_rr = rr_ptr;

    always_comb begin
        grant_owner = OWN_I;
        if (d_req)
            grant_owner = OWN_D;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one memory port; MEM_ARB_RR_EN selects round-robin
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_we,
    output logic              m_re,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [31:0]       i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              rr_ptr;
    logic              grant_valid;
    logic              grant_owner;
    logic              busy;

    mem_arb_grant u_grant (
        .i_req       (i_req),
        .d_req       (d_req),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

`ifdef MEM_ARB_RR_EN
    logic rr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_q <= OWN_I;
        else if (state == IDLE && grant_valid)
            rr_q <= grant_owner;
    end

    assign rr_ptr = rr_q;
`else
    assign rr_ptr = OWN_I;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= OWN_I;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state   <= BUSY;
                        cnt     <= '0;
                        owner   <= grant_owner;
                        we_q    <= (grant_owner == OWN_D) && d_we;
                        addr_q  <= (grant_owner == OWN_D) ? d_addr : i_addr;
                        wdata_q <= (grant_owner == OWN_D) ? d_wdata : '0;
                    end
                end
                BUSY: begin
                    if (cnt == LAST_CNT) begin
                        state <= RESP;
                        // Writes return nothing, so d_rdata keeps the last read value
                        if (owner == OWN_I)
                            i_rdata_q <= fetch_word(m_rdata[63:0], addr_q[2]);
                        else if (!we_q)
                            d_rdata_q <= m_rdata;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == BUSY);
    assign m_addr  = busy ? addr_q : '0;
    assign m_wdata = busy ? wdata_q : '0;
    assign m_we    = busy && (owner == OWN_D) && we_q;
    assign m_re    = busy && !m_we;

    assign i_ack   = (state == RESP) && (owner == OWN_I);
    assign d_ack   = (state == RESP) && (owner == OWN_D);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 64, meaning memory/data-port word width.
REQ-003 SHALL have parameter LATENCY, default 1, legal range 1..15, meaning memory access cycles per transaction.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports i_req in 1, i_addr in ADDR_W, i_rdata out 32 and i_ack out 1, forming the instruction-fetch requester.
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W, d_rdata out DATA_W and d_ack out 1, forming the data requester.
REQ-008 SHALL have ports m_addr out ADDR_W, m_wdata out DATA_W, m_we out 1, m_re out 1 and m_rdata in DATA_W, forming the shared single-port memory side.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, RESP; the only transitions are IDLE->BUSY on grant, BUSY->RESP when the wait counter reaches LATENCY-1, RESP->IDLE unconditionally.
REQ-010 SHALL, in IDLE with any request pending, grant one requester and register its address, write-data, write-enable and an owner bit.
REQ-011 SHALL, when both requests are pending and MEM_ARB_RR_EN is undefined, grant data over instruction.
REQ-012 SHALL, in BUSY, drive m_addr/m_wdata from the registered values, with m_we=owner_is_data&&we and m_re=!m_we, for exactly LATENCY cycles.
REQ-013 SHALL drive m_we=0, m_re=0, m_addr=0 and m_wdata=0 in IDLE and RESP.
REQ-014 SHALL capture m_rdata on the final BUSY cycle into a response register.
REQ-015 SHALL pulse exactly one ack (i_ack or d_ack) high for the single RESP cycle, to the owner only.
REQ-016 SHALL return i_rdata as bits [63:32] of the response when the registered i_addr[2]=1, else bits [31:0].
REQ-017 SHALL hold i_rdata/d_rdata stable from RESP until the next read response to the same port; a data write leaves d_rdata unchanged.
REQ-018 SHALL make request-to-ack latency LATENCY+1 cycles and throughput one transaction per LATENCY+2 cycles.
REQ-019 SHALL require each requester to hold req and its payload until its ack; a req deasserted before ack is ignored after grant (the transaction completes).
REQ-020 SHALL not re-grant in the RESP cycle even if the owner's req is still high; the IDLE cycle that follows gives the requester time to drop it.
REQ-021 SHALL use a wait counter of 4 bits that clears on entry to BUSY and never wraps, since LATENCY<=15.

Reset
REQ-022 SHALL, on rst assertion at any time including mid-transaction, force IDLE, clear the counter, owner and rr pointer, set i_rdata/d_rdata to 0, drive all m_* outputs to 0, and drive both acks to 0, with no ack for the aborted transaction.
REQ-023 SHALL start arbitration on the first rising clk edge after rst deasserts.

Configuration
REQ-024 SHALL compile in round-robin arbitration when macro MEM_ARB_RR_EN is defined: on a conflict, grant the requester not served last; the rr pointer updates on each grant.
REQ-025 SHALL, without MEM_ARB_RR_EN, use fixed data priority and contain no rr pointer register.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and the owner encoding (OWN_I=0, OWN_D=1) in shared package mem_arb_pkg.
REQ-027 SHALL isolate the grant decision in sub-module mem_arb_grant (inputs i_req, d_req, rr pointer; outputs grant_valid, grant_owner).

Verification
REQ-028 SHALL cover a solo fetch: LATENCY=1, i_req with i_addr=0x4 and m_rdata=0x1111_2222_3333_4444 -> i_ack on cycle 2, i_rdata=0x1111_2222.
REQ-029 SHALL cover a data write: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF -> m_we=1 for exactly LATENCY cycles with m_addr=0x100, then one d_ack and d_rdata unchanged.
REQ-030 SHALL cover a simultaneous request without the macro: i_req and d_req high together at cycle 0 -> d_ack precedes i_ack, i_ack arriving 2*(LATENCY+2)-1 cycles after cycle 0.
REQ-031 SHALL cover a simultaneous request with MEM_ARB_RR_EN: both req held high for 4 transactions -> grant order D,I,D,I.
REQ-032 SHALL cover reset mid-operation: LATENCY=3, rst asserted during the 2nd BUSY cycle -> m_re=0 immediately, no ack, FSM returns to IDLE and the next request is served normally.
REQ-033 SHALL cover a long latency: LATENCY=15, d read -> m_re high exactly 15 cycles and d_ack at cycle 16.
